// File: rtl/wc_frame_ctrl.sv
// wc_frame_ctrl: parses the pad word stream into weight/tile loads, launches the
// WC_5_3 core with a completion timeout and serialises its three results to the pads.
module wc_frame_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [9:0]  d_i,
    input  logic        d_vld_i,
    output logic [29:0] core_g_o,
    output logic [49:0] core_d_o,
    output logic        core_start_o,
    input  logic        core_done_i,
    input  logic [29:0] core_y_i,
    output logic [9:0]  z_o,
    output logic        z_vld_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_G = 3'd1;
    localparam logic [2:0] LOAD_D = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] EMIT   = 3'd5;

    logic [2:0]  st_q, st_d, wcnt_q, wcnt_d;
    logic [9:0]  tcnt_q, tcnt_d, z_q, z_d;
    logic [29:0] g_q, g_d, res_q, res_d;
    logic [49:0] dt_q, dt_d;
    logic        wl_q, wl_d, start_q, zv_q, zv_d, busy_q, err_q, err_d;

    always_comb begin
        st_d   = st_q;
        wcnt_d = wcnt_q;
        tcnt_d = tcnt_q;
        wl_d   = wl_q;
        g_d    = g_q;
        dt_d   = dt_q;
        res_d  = res_q;
        err_d  = err_q;
        z_d    = '0;
        zv_d   = 1'b0;
        case (st_q)
            IDLE: if (d_vld_i) begin
                wcnt_d = '0;
                if (d_i[9:8] == 2'b01) begin
                    st_d = LOAD_G;
                    wl_d = 1'b0;
                end else if (d_i[9:8] == 2'b10) begin
                    st_d  = wl_q ? LOAD_D : IDLE;
                    err_d = err_q | ~wl_q;
                end
            end
            LOAD_G: if (d_vld_i) begin
                for (int i = 0; i < 3; i++)
                    if (wcnt_q == 3'(i)) g_d[i*10 +: 10] = d_i;
                wcnt_d = wcnt_q + 3'd1;
                if (wcnt_q == 3'd2) begin
                    wl_d = 1'b1;
                    st_d = IDLE;
                end
            end
            LOAD_D: if (d_vld_i) begin
                for (int i = 0; i < 5; i++)
                    if (wcnt_q == 3'(i)) dt_d[i*10 +: 10] = d_i;
                wcnt_d = wcnt_q + 3'd1;
                if (wcnt_q == 3'd4) st_d = START;
            end
            START: begin
                tcnt_d = '0;
                st_d   = WAIT;
            end
            WAIT: if (core_done_i) begin
                // y0 is launched straight from core_y so it appears the cycle EMIT starts
                res_d  = core_y_i;
                wcnt_d = '0;
                z_d    = core_y_i[9:0];
                zv_d   = 1'b1;
                st_d   = EMIT;
            end else if (tcnt_q == 10'(TIMEOUT - 1)) begin
                err_d = 1'b1;
                st_d  = IDLE;
            end else begin
                tcnt_d = tcnt_q + 10'd1;
            end
            EMIT: begin
                wcnt_d = wcnt_q + 3'd1;
                st_d   = (wcnt_q == 3'd2) ? IDLE : EMIT;
                zv_d   = wcnt_q != 3'd2;
                z_d    = (wcnt_q == 3'd2) ? 10'd0 : (wcnt_q == 3'd0) ? res_q[19:10] : res_q[29:20];
            end
            default: st_d = IDLE;
        endcase
        if (d_vld_i && (st_q == START || st_q == WAIT || st_q == EMIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= IDLE;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            wl_q    <= 1'b0;
            g_q     <= '0;
            dt_q    <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            z_q     <= '0;
            zv_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            wl_q    <= wl_d;
            g_q     <= g_d;
            dt_q    <= dt_d;
            res_q   <= res_d;
            start_q <= st_d == START;
            z_q     <= z_d;
            zv_q    <= zv_d;
            busy_q  <= st_d != IDLE;
            err_q   <= err_d;
        end
    end

    assign core_g_o     = g_q;
    assign core_d_o     = dt_q;
    assign core_start_o = start_q;
    assign z_o          = z_q;
    assign z_vld_o      = zv_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
endmodule
